// File: rtl/stream_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_buf_pkg
//  Purpose  : Shared widths, depth and types for the stream buffer controller.
//  Revision : 1.0 - initial release
// ============================================================================
package stream_buf_pkg;

    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16384;
    localparam int LEVEL_W = 15;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [LEVEL_W-1:0] level_t;

endpackage
`default_nettype wire

// File: rtl/stream_buf_skid.sv
`default_nettype none
// ============================================================================
//  Module   : stream_buf_skid
//  Purpose  : Two-entry output stage holding bytes returned by the SRAM read
//             port until the downstream consumer accepts them. The read
//             issue logic upstream never sends a byte when both entries are
//             occupied and no pop is happening.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_buf_skid
    import stream_buf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  data_t      i_data,
    output logic       o_valid,
    input  logic       i_ready,
    output data_t      o_data,
    output logic [1:0] o_count
);

    logic [1:0] count_q, count_d;
    data_t      head_q,  head_d;
    data_t      tail_q,  tail_d;
    logic       w_pop;

    // Valid is forced low during reset so nothing leaves while state clears
    assign o_valid = (count_q != 2'd0) && !rst;
    assign w_pop   = o_valid && i_ready;
    assign o_data  = head_q;
    assign o_count = count_q;

    // Next-state for the two entries; head is always the oldest byte
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            2'd0: begin
                if (i_valid) begin
                    head_d  = i_data;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (w_pop && i_valid) begin
                    head_d = i_data;
                end else if (w_pop) begin
                    count_d = 2'd0;
                end else if (i_valid) begin
                    tail_d  = i_data;
                    count_d = 2'd2;
                end
            end
            default: begin
                if (w_pop) begin
                    head_d = tail_q;
                    if (i_valid) begin
                        tail_d = i_data;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
        endcase
    end

    // Entry registers with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stream_buf_ctrl
//  Purpose  : Byte stream buffer controller driving an external 16384x8
//             two-port SRAM (1-cycle read latency) with a 2-entry output
//             stage. Optional watermark outputs LEVEL / ALMOST_FULL are built
//             when the macro STREAM_BUF_WATERMARK_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_buf_ctrl
    import stream_buf_pkg::*;
#(
    parameter int AF_THRESH = 16000
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              IN_READY,
    output logic              OUT_VALID,
    output logic [DATA_W-1:0] OUT_DATA,
    input  logic              OUT_READY,
    output logic              W_EN,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [DATA_W-1:0] W_DATA,
    output logic              R_EN,
    output logic [ADDR_W-1:0] R_ADDR,
    input  logic [DATA_W-1:0] R_DATA
`ifdef STREAM_BUF_WATERMARK_EN
    ,
    output logic [LEVEL_W-1:0] LEVEL,
    output logic               ALMOST_FULL
`endif
);

    addr_t      wptr_q, wptr_d;
    addr_t      rptr_q, rptr_d;
    level_t     used_q, used_d;
    logic       inflight_q, inflight_d;
    logic [1:0] w_held;
    logic [2:0] w_occ;
    logic       w_push;
    logic       w_pop;
    logic       w_rd;

    // Write side: a push goes straight to the SRAM in the same cycle
    assign IN_READY = !RST && (used_q != level_t'(DEPTH));
    assign w_push   = IN_VALID && IN_READY;
    assign W_EN     = w_push;
    assign W_ADDR   = wptr_q;
    assign W_DATA   = IN_DATA;

    // Read side: issue a read only when the output stage will have room for
    // the returning byte, counting the one already in flight. Because used
    // only counts bytes already written, a read can never hit this cycle's
    // write address.
    assign w_pop  = OUT_VALID && OUT_READY;
    assign w_occ  = {1'b0, w_held} + {2'b00, inflight_q};
    assign w_rd   = !RST && (used_q != '0) && (w_occ < (3'd2 + {2'b00, w_pop}));
    assign R_EN   = w_rd;
    assign R_ADDR = rptr_q;

    // Pointer, occupancy and in-flight next-state
    always_comb begin
        wptr_d     = w_push ? wptr_q + addr_t'(1) : wptr_q;
        rptr_d     = w_rd   ? rptr_q + addr_t'(1) : rptr_q;
        inflight_d = w_rd;
        used_d     = used_q;
        case ({w_push, w_rd})
            2'b10:   used_d = used_q + level_t'(1);
            2'b01:   used_d = used_q - level_t'(1);
            default: used_d = used_q;
        endcase
    end

    // Control registers; clearing inflight drops any read data still returning
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            used_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            used_q     <= used_d;
            inflight_q <= inflight_d;
        end
    end

    stream_buf_skid u_skid (
        .clk     (CLK),
        .rst     (RST),
        .i_valid (inflight_q),
        .i_data  (R_DATA),
        .o_valid (OUT_VALID),
        .i_ready (OUT_READY),
        .o_data  (OUT_DATA),
        .o_count (w_held)
    );

    // A threshold above DEPTH can never be reached; nothing extra is built
    if (AF_THRESH > DEPTH) begin : g_af_thresh_unreachable
    end

`ifdef STREAM_BUF_WATERMARK_EN
    localparam level_t            c_AF_LEVEL  = level_t'(AF_THRESH);
    localparam logic [LEVEL_W:0]  c_DEPTH_EXT = (LEVEL_W + 1)'(DEPTH);

    level_t           level_q, level_d;
    logic [LEVEL_W:0] w_total;

    // Total bytes held anywhere in the buffer, saturated at DEPTH
    always_comb begin
        w_total = {1'b0, used_q} + {{(LEVEL_W-1){1'b0}}, w_held}
                + {{LEVEL_W{1'b0}}, inflight_q};
        level_d = (w_total > c_DEPTH_EXT) ? level_t'(DEPTH) : w_total[LEVEL_W-1:0];
    end

    // Registered fill level
    always_ff @(posedge CLK) begin
        if (RST) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign LEVEL       = RST ? '0 : level_q;
    assign ALMOST_FULL = !RST && (level_q >= c_AF_LEVEL);
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_buf_ctrl
//  Purpose  : Directed self-checking bench for stream_buf_ctrl with a
//             behavioural 16384x8 SRAM (1-cycle read latency).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_buf_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic [7:0]  IN_DATA;
    logic        IN_READY;
    logic        OUT_VALID;
    logic [7:0]  OUT_DATA;
    logic        OUT_READY;
    logic        W_EN;
    logic [13:0] W_ADDR;
    logic [7:0]  W_DATA;
    logic        R_EN;
    logic [13:0] R_ADDR;
    logic [7:0]  R_DATA;
`ifdef STREAM_BUF_WATERMARK_EN
    logic [14:0] LEVEL;
    logic        ALMOST_FULL;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    stream_buf_ctrl #(.AF_THRESH(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IN_VALID    (IN_VALID),
        .IN_DATA     (IN_DATA),
        .IN_READY    (IN_READY),
        .OUT_VALID   (OUT_VALID),
        .OUT_DATA    (OUT_DATA),
        .OUT_READY   (OUT_READY),
        .W_EN        (W_EN),
        .W_ADDR      (W_ADDR),
        .W_DATA      (W_DATA),
        .R_EN        (R_EN),
        .R_ADDR      (R_ADDR),
        .R_DATA      (R_DATA)
`ifdef STREAM_BUF_WATERMARK_EN
        ,
        .LEVEL       (LEVEL),
        .ALMOST_FULL (ALMOST_FULL)
`endif
    );

    // SRAM model: synchronous write, registered read
    logic [7:0] mem [0:16383];
    always @(posedge CLK) begin
        if (W_EN) mem[W_ADDR] <= W_DATA;
        if (R_EN) R_DATA <= mem[R_ADDR];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; IN_DATA = 8'h00;
        adv();
        RST = 1'b0;
    endtask

    initial begin
        int tx;
        int rx;
        logic full;
        logic w_wrap;
        logic r_wrap;
        logic [13:0] prev_w;
        logic [13:0] prev_r;

        // ---------------- reset state ----------------
        RST = 1'b1; IN_VALID = 1'b1; IN_DATA = 8'h77; OUT_READY = 1'b1;
        adv();
        mid();
        chk("rst_in_ready",  32'(IN_READY),  32'd0);
        chk("rst_w_en",      32'(W_EN),      32'd0);
        chk("rst_r_en",      32'(R_EN),      32'd0);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        adv();
        RST = 1'b0; IN_VALID = 1'b0;
        mid();
        chk("rst_w_addr",   32'(W_ADDR),   32'd0);
        chk("rst_r_addr",   32'(R_ADDR),   32'd0);
        chk("rst_out_data", 32'(OUT_DATA), 32'd0);
        chk("rst_ready_up", 32'(IN_READY), 32'd1);
        adv();

        // ---------------- single byte latency ----------------
        IN_VALID = 1'b1; IN_DATA = 8'hA5; OUT_READY = 1'b1;
        mid();
        chk("c0_w_en",   32'(W_EN),   32'd1);
        chk("c0_w_addr", 32'(W_ADDR), 32'd0);
        chk("c0_w_data", 32'(W_DATA), 32'hA5);
        chk("c0_r_en",   32'(R_EN),   32'd0);
        adv();
        IN_VALID = 1'b0;
        mid();
        chk("c1_r_en",      32'(R_EN),      32'd1);
        chk("c1_r_addr",    32'(R_ADDR),    32'd0);
        chk("c1_out_valid", 32'(OUT_VALID), 32'd0);
        adv();
        mid();
        chk("c2_out_valid", 32'(OUT_VALID), 32'd0);
        chk("c2_r_en",      32'(R_EN),      32'd0);
        adv();
        mid();
        chk("c3_out_valid", 32'(OUT_VALID), 32'd1);
        chk("c3_out_data",  32'(OUT_DATA),  32'hA5);
        adv();
        mid();
        chk("c4_out_valid", 32'(OUT_VALID), 32'd0);
        adv();

        // ---------------- downstream stall ----------------
        OUT_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            IN_VALID = 1'b1; IN_DATA = 8'h10 + 8'(i);
            adv();
        end
        IN_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("stall_valid", 32'(OUT_VALID), 32'd1);
            chk("stall_data",  32'(OUT_DATA),  32'h10);
            chk("stall_r_en",  32'(R_EN),      32'd0);
            adv();
        end
        OUT_READY = 1'b1;
        rx = 0;
        for (int c = 0; c < 20 && rx < 4; c++) begin
            mid();
            if (OUT_VALID) begin
                chk("stall_drain_data", 32'(OUT_DATA), 32'(8'h10 + 8'(rx)));
                rx++;
            end
            adv();
        end
        chk("stall_drain_count", 32'(rx), 32'd4);

        // ---------------- fill to capacity ----------------
        do_reset();
        OUT_READY = 1'b0; IN_VALID = 1'b1;
        tx = 0; full = 1'b0;
        for (int c = 0; c < 17000 && !full; c++) begin
            IN_DATA = tx[7:0];
            mid();
            if (IN_READY) tx++;
            else full = 1'b1;
            if (!full) adv();
        end
        chk("fill_count",     32'(tx),        32'd16386);
        chk("full_w_en",      32'(W_EN),      32'd0);
        chk("full_out_valid", 32'(OUT_VALID), 32'd1);
        chk("full_out_data",  32'(OUT_DATA),  32'd0);
        adv();
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        rx = 0;
        for (int c = 0; c < 17000 && rx < 16386; c++) begin
            mid();
            if (OUT_VALID) begin
                chk("fill_drain_data", 32'(OUT_DATA), 32'(rx[7:0]));
                rx++;
            end
            adv();
        end
        chk("fill_drain_count", 32'(rx), 32'd16386);

        // ---------------- long stream with random back-pressure ----------------
        do_reset();
        tx = 0; rx = 0; w_wrap = 1'b0; r_wrap = 1'b0; prev_w = '0; prev_r = '0;
        for (int c = 0; c < 60000 && rx < 20000; c++) begin
            IN_VALID  = (tx < 20000);
            IN_DATA   = tx[7:0];
            OUT_READY = ($urandom_range(3) != 0);
            mid();
            if (IN_VALID && IN_READY) begin
                if (prev_w == 14'd16383 && W_ADDR == 14'd0) w_wrap = 1'b1;
                prev_w = W_ADDR;
                tx++;
            end
            if (R_EN) begin
                if (prev_r == 14'd16383 && R_ADDR == 14'd0) r_wrap = 1'b1;
                prev_r = R_ADDR;
            end
            if (OUT_VALID && OUT_READY) begin
                chk("stream_data", 32'(OUT_DATA), 32'(rx[7:0]));
                rx++;
            end
            adv();
        end
        IN_VALID = 1'b0;
        chk("stream_count", 32'(rx),     32'd20000);
        chk("stream_wwrap", 32'(w_wrap), 32'd1);
        chk("stream_rwrap", 32'(r_wrap), 32'd1);

        // ---------------- reset mid-operation ----------------
        do_reset();
        OUT_READY = 1'b0;
        for (int i = 0; i < 100; i++) begin
            IN_VALID = 1'b1; IN_DATA = 8'h40 + 8'(i);
            adv();
        end
        IN_VALID = 1'b0;
        adv(); adv(); adv();
        OUT_READY = 1'b1;
        mid();
        chk("rr_r_en", 32'(R_EN), 32'd1);
        adv();
        RST = 1'b1; OUT_READY = 1'b0;
        mid();
        chk("rr_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rr_r_en_rst",  32'(R_EN),      32'd0);
        adv();
        RST = 1'b0;
        mid();
        chk("post_out_valid", 32'(OUT_VALID), 32'd0);
        chk("post_w_addr",    32'(W_ADDR),    32'd0);
        chk("post_r_addr",    32'(R_ADDR),    32'd0);
        adv();
        IN_VALID = 1'b1; IN_DATA = 8'h3C; OUT_READY = 1'b1;
        mid();
        chk("post_w_en",     32'(W_EN),   32'd1);
        chk("post_w_addr0",  32'(W_ADDR), 32'd0);
        adv();
        IN_VALID = 1'b0;
        mid();
        chk("post_c1_valid", 32'(OUT_VALID), 32'd0);
        adv();
        mid();
        chk("post_c2_valid", 32'(OUT_VALID), 32'd0);
        adv();
        mid();
        chk("post_c3_valid", 32'(OUT_VALID), 32'd1);
        chk("post_c3_data",  32'(OUT_DATA),  32'h3C);
        adv();

`ifdef STREAM_BUF_WATERMARK_EN
        // ---------------- watermark ----------------
        do_reset();
        OUT_READY = 1'b0;
        for (int k = 0; k < 10; k++) begin
            IN_VALID = 1'b1; IN_DATA = 8'(k);
            mid();
            chk("wm_level_fill", 32'(LEVEL),       (k == 0) ? 32'd0 : 32'(k - 1));
            chk("wm_af_fill",    32'(ALMOST_FULL), (k >= 9) ? 32'd1 : 32'd0);
            adv();
        end
        IN_VALID = 1'b0;
        adv(); adv(); adv();
        mid();
        chk("wm_level_10", 32'(LEVEL),       32'd10);
        chk("wm_af_10",    32'(ALMOST_FULL), 32'd1);
        adv();
        for (int n = 1; n <= 4; n++) begin
            OUT_READY = 1'b1;
            adv();
            OUT_READY = 1'b0;
            adv(); adv(); adv();
            mid();
            chk("wm_level_drain", 32'(LEVEL),       32'(10 - n));
            chk("wm_af_drain",    32'(ALMOST_FULL), (10 - n >= 8) ? 32'd1 : 32'd0);
            adv();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_buf_ctrl.md
STREAM_BUF_CTRL -- requirements
Module: stream_buf_ctrl

Interface
REQ-001 Parameter AF_THRESH, default 16000, SHALL set the ALMOST_FULL level (used only with STREAM_BUF_WATERMARK_EN).
REQ-002 CLK  input  1  single clock for all logic; rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 IN_VALID  input  1  upstream byte valid.
REQ-005 IN_DATA  input  8  upstream byte.
REQ-006 IN_READY  output  1  buffer can accept a byte.
REQ-007 OUT_VALID  output  1  downstream byte valid.
REQ-008 OUT_DATA  output  8  downstream byte.
REQ-009 OUT_READY  input  1  downstream accepts the byte.
REQ-010 W_EN, W_ADDR[13:0], W_DATA[7:0]  outputs  write port to the 16384x8 two-port SRAM.
REQ-011 R_EN, R_ADDR[13:0]  outputs; R_DATA[7:0] input  read port of the same SRAM; R_DATA valid 1 cycle after R_EN.

Function
REQ-012 Push = IN_VALID & IN_READY; W_EN SHALL equal push, with W_ADDR = wptr and W_DATA = IN_DATA, combinationally, in the same cycle.
REQ-013 wptr and rptr SHALL be 14-bit and wrap 16383 -> 0; wptr increments on push; rptr increments on R_EN.
REQ-014 used (15-bit, 0..16384) SHALL count bytes written but not yet read-issued; +1 on push, -1 on R_EN, unchanged when both occur.
REQ-015 IN_READY SHALL be 1 iff used < 16384 and RST = 0; no push when used = 16384.
REQ-016 Output stage SHALL hold up to 2 bytes (held); inflight = 1 in the cycle after R_EN.
REQ-017 Pop = OUT_VALID & OUT_READY; R_EN SHALL be 1 iff used != 0 and held + inflight - pop < 2; R_ADDR = rptr.
REQ-018 R_DATA SHALL be captured into the output stage in the cycle after R_EN; OUT_VALID = (held != 0); OUT_DATA = oldest held byte.
REQ-019 OUT_VALID/OUT_DATA SHALL be stable while OUT_VALID & !OUT_READY.
REQ-020 Byte pushed in cycle t SHALL first appear on OUT_VALID at t+3 when the buffer is empty.
REQ-021 With OUT_READY held high and continuous input, throughput SHALL be 1 byte/cycle.
REQ-022 Byte order out SHALL equal byte order in; no loss, no duplication.
REQ-023 A read SHALL never target an address written in the same cycle (guaranteed by REQ-012/014).

Reset
REQ-024 While RST = 1: IN_READY = 0, W_EN = 0, R_EN = 0, OUT_VALID = 0.
REQ-025 On RST: wptr = 0, rptr = 0, used = 0, held = 0, inflight = 0, OUT_DATA = 0, W_ADDR = R_ADDR = 0.
REQ-026 RST asserted mid-operation SHALL discard all buffered and inflight bytes; an R_DATA returning after reset SHALL be ignored.

Configuration
REQ-027 Macro STREAM_BUF_WATERMARK_EN defined: outputs LEVEL[14:0] = used + inflight + held (saturating at 16384, registered) and ALMOST_FULL = (LEVEL >= AF_THRESH), both 0 in reset.
REQ-028 Macro STREAM_BUF_WATERMARK_EN undefined: LEVEL and ALMOST_FULL ports and logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-029 Package stream_buf_pkg SHALL hold ADDR_W = 14, DATA_W = 8, DEPTH = 16384, and LEVEL_W = 15.
REQ-030 The 2-entry output stage SHALL be sub-module stream_buf_skid (in: valid/data; out: valid/ready/data; count output).
REQ-031 The SRAM SHALL be instantiated outside this block by the parent.

Verification
REQ-032 After reset, push 0xA5 at cycle 0 with OUT_READY = 1 -> W_EN = 1 with W_ADDR = 0 at cycle 0; R_EN with R_ADDR = 0 at cycle 1; OUT_VALID = 1 with 0xA5 at cycle 3.
REQ-033 OUT_READY = 0, push 16384 bytes -> IN_READY = 0 after 16384 pushes (16386 including held); a further IN_VALID is not written.
REQ-034 Stream 20000 incrementing bytes with random OUT_READY -> the output sequence matches, and W_ADDR/R_ADDR wrap through 16383 -> 0.
REQ-035 OUT_READY low for 5 cycles with OUT_VALID = 1 -> OUT_DATA is stable and R_EN = 0 once held = 2.
REQ-036 RST pulsed while 100 bytes are buffered and R_EN is inflight -> OUT_VALID = 0 next cycle; the next pushed byte 0x3C is written to address 0 and is the first output.
REQ-037 With STREAM_BUF_WATERMARK_EN and AF_THRESH = 8 -> ALMOST_FULL rises when LEVEL reaches 8 and falls below 8.
